mdu_rs: RTL and testbench
=========================

# mdu_rs

Reservation station for the multiply/divide unit. It sits between dispatch and `mdu`. It buffers renamed M-extension micro-ops, captures missing source operands from CDB broadcasts, and issues the oldest fully-ready entry to `mdu` whenever `mdu_rdy` is high. Entries are kept age-ordered in a collapsing queue, so slot 0 always holds the oldest entry.

## Interface
- `DEPTH`, 4: number of entries; must be ≥ 2.
- `CDB_PORTS`, 2: number of CDB broadcast ports snooped for wakeup.
- `clk` input, 1: clock; all state updates on its rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `flush` input, 1: squash all entries; synchronous.
- `rs_rdy` output, 1: free entry available; may accept a dispatch this cycle.
- `dispatch_packet` input, `instruction_t`: new micro-op; accepted when `is_valid && rs_rdy && !flush`.
- `cdb_bus` input, `writeback_packet_t [CDB_PORTS]`: results broadcast as `is_valid`, `dest_tag`, `result`.
- `mdu_rdy` input, 1: `mdu` can accept an instruction this cycle.
- `mdu_packet` output, `instruction_t`: issued micro-op. `is_valid` is high for exactly one cycle per issue.

## Operation
- Each entry holds a valid bit and a full `instruction_t`.
- A source is ready when its `is_renamed` flag is 0.
- **Wakeup:** for each valid entry and each renamed source, if any `cdb_bus[p].is_valid` is set and its `dest_tag` equals `src.tag`:
  - copy `result` into `src.data`;
  - clear `is_renamed`;
  - if two ports match the same tag, the lowest-index port wins (same value by construction).
- **Dispatch-time capture:** the incoming `dispatch_packet` is snooped against `cdb_bus` in the same cycle. An operand broadcast in its dispatch cycle is never lost.
- **Select:** choose the lowest-index valid entry with both sources ready.
- **Issue:**
  - `mdu_packet` is driven combinationally from the selected entry.
  - `mdu_packet.is_valid = mdu_rdy && selected_exists && !flush`.
- **Removal:** on the issue edge, the selected entry is removed and all younger entries shift down one slot. Wakeups in that cycle apply to the shifted copies.
- **Allocation:** a dispatched entry is written to the slot at index `count`, or `count-1` if an issue occurs in the same cycle. Age order is preserved.
- **Simultaneous issue, dispatch and wakeup** in one cycle: all three apply. Net `count` is unchanged.
- **Flush:**
  - all valid bits clear at the next edge;
  - `mdu_packet.is_valid` = 0 during the flush cycle;
  - a dispatch in the flush cycle is dropped.
- **Full:** `rs_rdy = (count != DEPTH)`, computed from registered state only. There is no same-cycle credit from an issue. Dispatch while `!rs_rdy` is a protocol error and has a bench assertion.
- **Empty:** `mdu_packet.is_valid` = 0 and the payload is don't-care, driven `'0`.

## Timing
- While `rst_n` is low:
  - all valid bits = 0 and `count` = 0;
  - `rs_rdy` = 0;
  - `mdu_packet` = `'0`.
- `rs_rdy` rises combinationally once `rst_n` is high.
- Reset asserted mid-operation discards all entries immediately. No partial issue occurs.
- Dispatch at edge N with both sources ready: eligible to issue in cycle N+1, so minimum latency is 1 cycle.
- Last operand broadcast on the CDB in cycle N (captured at edge N+1): eligible to issue in cycle N+1. Same-cycle issue depends on `MDU_RS_WAKEUP_BYPASS_EN`.
- `mdu_rdy` low: no issue and no entry change except wakeup and dispatch.

## Configuration
- **`MDU_RS_WAKEUP_BYPASS_EN` defined:**
  - an entry whose last missing operand matches a CDB broadcast in the current cycle is treated as ready for select in that same cycle;
  - `mdu_packet` carries the forwarded `result` in place of the stale `data`;
  - zero-cycle wakeup-to-issue.
- **Not defined:** readiness comes only from registered state, giving one cycle from broadcast to issue. This variant is the shorter critical path.

## Structure
- `uarch_pkg` additions:
  - `MDU_RS_DEPTH` (default for `DEPTH`);
  - `CDB_PORTS`;
  - `rs_entry_t` (valid + `instruction_t`).
- `instruction_t`, `writeback_packet_t`, `TAG_WIDTH`, and `src.tag`/`is_renamed`/`data` already live in `uarch_pkg`/`riscv_isa_pkg`.
- One sub-module: `rs_wakeup`, a combinational compare of one source operand against all CDB ports. It returns the updated operand and a hit flag, and is instantiated per entry-source and for the dispatch packet.

## Test plan
- **Ready dispatch:** dispatch MUL with rs1=3, rs2=5 (both ready), `mdu_rdy`=1 → `mdu_packet.is_valid` high one cycle after acceptance with data 3/5 and matching `dest_tag`; `count` returns to 0.
- **Wakeup:** dispatch DIV with rs1 ready (10) and rs2 renamed to tag 7; in a later cycle broadcast tag 7 with result 3 → rs2.data=3 and `is_renamed`=0. Issue occurs in the broadcast cycle with `MDU_RS_WAKEUP_BYPASS_EN` defined, or the next cycle without it.
- **Oldest-first ordering:** fill all 4 entries with tags 1–4, where tag 2 and tag 4 entries are ready and `mdu_rdy` is held low → `rs_rdy`=0. Then raise `mdu_rdy` → the tag 2 entry issues before the tag 4 entry; the remaining entries shift down.
- **Simultaneous events:** in one cycle, issue from a full station while a CDB broadcast wakes another entry and a dispatch is attempted → dispatch is ignored (`rs_rdy`=0), the wakeup is retained, and `count`=3 afterwards.
- **Dispatch-cycle capture:** dispatch rs1 renamed to tag 9 in the same cycle that tag 9 broadcasts 0xFFFF_FFF6 → the stored rs1 is ready with 0xFFFF_FFF6.
- **Flush and reset:** flush with 3 valid entries while `mdu_rdy`=1 → no issue that cycle, empty next cycle, `rs_rdy`=1. Assert `rst_n` low mid-operation → outputs go to `'0` asynchronously.

Source files
------------

// File: rtl/mdu_rs_pkg.sv
// Shared types for the multiply/divide reservation station: micro-op,
// CDB writeback packet and the RS entry wrapper.
package mdu_rs_pkg;

  localparam int XLEN         = 32;
  localparam int TAG_WIDTH    = 6;
  localparam int MDU_RS_DEPTH = 4;
  localparam int CDB_PORTS    = 2;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM,    MDU_REMU
  } mdu_op_e;

  typedef struct packed {
    logic                 is_renamed;
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]      data;
  } src_operand_t;

  typedef struct packed {
    logic                 is_valid;
    mdu_op_e              op;
    logic [TAG_WIDTH-1:0] dest_tag;
    src_operand_t         src1;
    src_operand_t         src2;
  } instruction_t;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [XLEN-1:0]      result;
  } writeback_packet_t;

  typedef struct packed {
    logic         valid;
    instruction_t instr;
  } rs_entry_t;

endpackage

// File: rtl/mdu_rs_wakeup.sv
// One source operand compared against every CDB port; returns the operand
// with the broadcast result captured and a hit flag.
module rs_wakeup import mdu_rs_pkg::*; #(
  parameter int PORTS = 2
) (
  input  src_operand_t                  src_i,
  input  writeback_packet_t [PORTS-1:0] cdb_i,
  output src_operand_t                  src_o,
  output logic                          hit_o
);

  always_comb begin
    src_o = src_i;
    hit_o = 1'b0;
    // descending scan so the lowest-index matching port lands last
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (src_i.is_renamed && cdb_i[p].is_valid && cdb_i[p].dest_tag == src_i.tag) begin
        src_o.data       = cdb_i[p].result;
        src_o.is_renamed = 1'b0;
        hit_o            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdu_rs.sv
// Age-ordered collapsing reservation station feeding the MDU.
// MDU_RS_WAKEUP_BYPASS_EN: same-cycle CDB wakeup counts as ready for select.
module mdu_rs import mdu_rs_pkg::*; #(
  parameter int DEPTH     = MDU_RS_DEPTH,
  parameter int CDB_PORTS = mdu_rs_pkg::CDB_PORTS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  output logic                              rs_rdy,
  input  instruction_t                      dispatch_packet,
  input  writeback_packet_t [CDB_PORTS-1:0] cdb_bus,
  input  logic                              mdu_rdy,
  output instruction_t                      mdu_packet
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t    [DEPTH-1:0] ent_q, ent_d;
  logic         [CNT_W-1:0] count_q, count_d;
  src_operand_t [DEPTH-1:0] s1_w, s2_w;
  logic         [DEPTH-1:0] s1_hit, s2_hit, rdy;
  instruction_t [DEPTH-1:0] woken;
  rs_entry_t    [DEPTH:0]   nxt;
  src_operand_t             d1_w, d2_w;
  logic                     d1_hit, d2_hit;
  instruction_t             disp_w;
  logic                     sel_found, issue, accept;
  logic         [IDX_W-1:0] sel_idx;
  logic         [CNT_W-1:0] alloc;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rs_wakeup #(.PORTS(CDB_PORTS)) u_wk_s1 (
      .src_i(ent_q[i].instr.src1), .cdb_i(cdb_bus), .src_o(s1_w[i]), .hit_o(s1_hit[i]));
    rs_wakeup #(.PORTS(CDB_PORTS)) u_wk_s2 (
      .src_i(ent_q[i].instr.src2), .cdb_i(cdb_bus), .src_o(s2_w[i]), .hit_o(s2_hit[i]));
  end

  rs_wakeup #(.PORTS(CDB_PORTS)) u_wk_d1 (
    .src_i(dispatch_packet.src1), .cdb_i(cdb_bus), .src_o(d1_w), .hit_o(d1_hit));
  rs_wakeup #(.PORTS(CDB_PORTS)) u_wk_d2 (
    .src_i(dispatch_packet.src2), .cdb_i(cdb_bus), .src_o(d2_w), .hit_o(d2_hit));

  always_comb begin
    disp_w      = dispatch_packet;
    disp_w.src1 = d1_hit ? d1_w : dispatch_packet.src1;
    disp_w.src2 = d2_hit ? d2_w : dispatch_packet.src2;
    nxt         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woken[i]      = ent_q[i].instr;
      woken[i].src1 = s1_hit[i] ? s1_w[i] : ent_q[i].instr.src1;
      woken[i].src2 = s2_hit[i] ? s2_w[i] : ent_q[i].instr.src2;
      nxt[i].valid  = ent_q[i].valid;
      nxt[i].instr  = woken[i];
`ifdef MDU_RS_WAKEUP_BYPASS_EN
      rdy[i] = ent_q[i].valid && !woken[i].src1.is_renamed && !woken[i].src2.is_renamed;
`else
      rdy[i] = ent_q[i].valid && !ent_q[i].instr.src1.is_renamed &&
               !ent_q[i].instr.src2.is_renamed;
`endif
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue  = mdu_rdy && sel_found && !flush;
  assign rs_rdy = rst_n && (count_q != CNT_W'(DEPTH));
  assign accept = dispatch_packet.is_valid && rs_rdy && !flush;
  assign alloc  = count_q - CNT_W'(issue);

  always_comb begin
    mdu_packet = '0;
    if (sel_found) begin
`ifdef MDU_RS_WAKEUP_BYPASS_EN
      mdu_packet = woken[sel_idx];
`else
      mdu_packet = ent_q[sel_idx].instr;
`endif
      mdu_packet.is_valid = issue;
    end
  end

  // Collapse above the issued slot, then append the dispatch behind the survivors.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q - CNT_W'(issue) + CNT_W'(accept);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue && i >= int'(sel_idx)) ? nxt[i+1] : nxt[i];
      if (accept && i == int'(alloc)) begin
        ent_d[i].valid = 1'b1;
        ent_d[i].instr = disp_w;
      end
    end
    if (flush) begin
      ent_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mdu_rs.sv
// Directed bench for mdu_rs: dispatch, wakeup, ordering, collapse, flush, reset.
module tb_mdu_rs;
  import mdu_rs_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst_n, flush, mdu_rdy, rs_rdy, allow_ovf;
  instruction_t                      dispatch_packet, mdu_packet;
  writeback_packet_t [CDB_PORTS-1:0] cdb_bus;
  int                                n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mdu_rs dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rs_rdy(rs_rdy),
    .dispatch_packet(dispatch_packet), .cdb_bus(cdb_bus),
    .mdu_rdy(mdu_rdy), .mdu_packet(mdu_packet)
  );

  always @(posedge clk)
    if (rst_n && !allow_ovf)
      assert (!(dispatch_packet.is_valid && !rs_rdy)) else $error("dispatch while rs_rdy low");

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic instruction_t mk(input mdu_op_e op, input logic [5:0] dest,
                                      input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                                      input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    instruction_t p;
    p.is_valid        = 1'b1;
    p.op              = op;
    p.dest_tag        = dest;
    p.src1.is_renamed = r1;
    p.src1.tag        = t1;
    p.src1.data       = d1;
    p.src2.is_renamed = r2;
    p.src2.tag        = t2;
    p.src2.data       = d2;
    return p;
  endfunction

  function automatic writeback_packet_t wb(input logic [5:0] tag, input logic [31:0] res);
    writeback_packet_t w;
    w.is_valid = 1'b1;
    w.dest_tag = tag;
    w.result   = res;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mdu_rdy = 1'b0; allow_ovf = 1'b0;
    dispatch_packet = '0; cdb_bus = '0;
    #12;
    chk("rst_rs_rdy", rs_rdy, 0);
    chk("rst_pkt", mdu_packet, 0);
    chk("rst_count", dut.count_q, 0);
    rst_n = 1'b1;
    #1;
    chk("rs_rdy_after_rst", rs_rdy, 1);
    step();

    // ready dispatch: issue one cycle after acceptance
    mdu_rdy = 1'b1;
    dispatch_packet = mk(MDU_MUL, 6'd5, 1'b0, 6'd0, 32'd3, 1'b0, 6'd0, 32'd5);
    @(negedge clk);
    chk("rd_empty_valid", mdu_packet.is_valid, 0);
    step();
    dispatch_packet = '0;
    @(negedge clk);
    chk("rd_valid", mdu_packet.is_valid, 1);
    chk("rd_src1", mdu_packet.src1.data, 3);
    chk("rd_src2", mdu_packet.src2.data, 5);
    chk("rd_dest", mdu_packet.dest_tag, 5);
    step();
    @(negedge clk);
    chk("rd_after_valid", mdu_packet.is_valid, 0);
    chk("rd_count", dut.count_q, 0);

    // wakeup of rs2 via CDB port 0
    step();
    dispatch_packet = mk(MDU_DIV, 6'd6, 1'b0, 6'd0, 32'd10, 1'b1, 6'd7, 32'd0);
    step();
    dispatch_packet = '0;
    @(negedge clk);
    chk("wk_wait_valid", mdu_packet.is_valid, 0);
    chk("wk_wait_count", dut.count_q, 1);
    step();
    cdb_bus[0] = wb(6'd7, 32'd3);
    @(negedge clk);
`ifdef MDU_RS_WAKEUP_BYPASS_EN
    chk("wk_byp_valid", mdu_packet.is_valid, 1);
    chk("wk_byp_src2", mdu_packet.src2.data, 3);
    chk("wk_byp_ren", mdu_packet.src2.is_renamed, 0);
    chk("wk_byp_src1", mdu_packet.src1.data, 10);
`else
    chk("wk_bcast_valid", mdu_packet.is_valid, 0);
`endif
    step();
    cdb_bus = '0;
    @(negedge clk);
`ifdef MDU_RS_WAKEUP_BYPASS_EN
    chk("wk_after_valid", mdu_packet.is_valid, 0);
    chk("wk_after_count", dut.count_q, 0);
`else
    chk("wk_valid", mdu_packet.is_valid, 1);
    chk("wk_src2", mdu_packet.src2.data, 3);
    chk("wk_ren", mdu_packet.src2.is_renamed, 0);
    chk("wk_dest", mdu_packet.dest_tag, 6);
`endif
    step();
    @(negedge clk);
    chk("wk_drained", dut.count_q, 0);

    // fill with tags 1..4 while mdu_rdy low; 2 and 4 ready
    step();
    mdu_rdy = 1'b0;
    dispatch_packet = mk(MDU_MUL,  6'd1, 1'b1, 6'd20, 32'd0,  1'b0, 6'd0,  32'd1);
    step();
    dispatch_packet = mk(MDU_MULH, 6'd2, 1'b0, 6'd0,  32'd22, 1'b0, 6'd0,  32'd2);
    step();
    dispatch_packet = mk(MDU_REM,  6'd3, 1'b0, 6'd0,  32'd33, 1'b1, 6'd21, 32'd0);
    step();
    dispatch_packet = mk(MDU_DIVU, 6'd4, 1'b0, 6'd0,  32'd44, 1'b0, 6'd0,  32'd4);
    step();
    dispatch_packet = '0;
    @(negedge clk);
    chk("full_rs_rdy", rs_rdy, 0);
    chk("full_count", dut.count_q, 4);
    chk("full_no_issue", mdu_packet.is_valid, 0);

    // issue + wakeup of tag-3 entry + dropped dispatch, all in one cycle
    step();
    mdu_rdy = 1'b1;
    cdb_bus[1] = wb(6'd21, 32'h55);
    allow_ovf = 1'b1;
    dispatch_packet = mk(MDU_MUL, 6'd9, 1'b0, 6'd0, 32'd9, 1'b0, 6'd0, 32'd9);
    @(negedge clk);
    chk("sim_valid", mdu_packet.is_valid, 1);
    chk("sim_dest", mdu_packet.dest_tag, 2);
    chk("sim_rs_rdy", rs_rdy, 0);
    step();
    cdb_bus = '0;
    dispatch_packet = '0;
    allow_ovf = 1'b0;
    @(negedge clk);
    chk("sim_count", dut.count_q, 3);
    chk("ord2_valid", mdu_packet.is_valid, 1);
    chk("ord2_dest", mdu_packet.dest_tag, 3);
    chk("ord2_src2", mdu_packet.src2.data, 32'h55);
    chk("ord2_ren", mdu_packet.src2.is_renamed, 0);
    step();
    @(negedge clk);
    chk("ord3_dest", mdu_packet.dest_tag, 4);
    chk("ord3_valid", mdu_packet.is_valid, 1);
    chk("ord3_count", dut.count_q, 2);

    // refill to 3 entries, then flush with a dispatch present
    step();
    mdu_rdy = 1'b0;
    dispatch_packet = mk(MDU_MUL, 6'd10, 1'b0, 6'd0, 32'd1, 1'b0, 6'd0, 32'd1);
    @(negedge clk);
    chk("refill_count", dut.count_q, 1);
    step();
    dispatch_packet = mk(MDU_MUL, 6'd11, 1'b0, 6'd0, 32'd1, 1'b0, 6'd0, 32'd1);
    step();
    dispatch_packet = '0;
    @(negedge clk);
    chk("pre_flush_count", dut.count_q, 3);
    step();
    flush = 1'b1;
    mdu_rdy = 1'b1;
    dispatch_packet = mk(MDU_MUL, 6'd13, 1'b0, 6'd0, 32'd1, 1'b0, 6'd0, 32'd1);
    @(negedge clk);
    chk("flush_no_issue", mdu_packet.is_valid, 0);
    step();
    flush = 1'b0;
    dispatch_packet = '0;
    @(negedge clk);
    chk("flush_count", dut.count_q, 0);
    chk("flush_rs_rdy", rs_rdy, 1);
    chk("flush_valid", mdu_packet.is_valid, 0);

    // operand broadcast in the dispatch cycle is captured
    step();
    mdu_rdy = 1'b0;
    dispatch_packet = mk(MDU_MULHU, 6'd12, 1'b1, 6'd9, 32'd0, 1'b0, 6'd0, 32'd2);
    cdb_bus[1] = wb(6'd9, 32'hFFFF_FFF6);
    step();
    dispatch_packet = '0;
    cdb_bus = '0;
    mdu_rdy = 1'b1;
    @(negedge clk);
    chk("cap_valid", mdu_packet.is_valid, 1);
    chk("cap_dest", mdu_packet.dest_tag, 12);
    chk("cap_src1", mdu_packet.src1.data, 32'hFFFF_FFF6);
    chk("cap_ren", mdu_packet.src1.is_renamed, 0);
    step();

    // asynchronous reset mid-operation
    mdu_rdy = 1'b0;
    dispatch_packet = mk(MDU_MUL, 6'd14, 1'b0, 6'd0, 32'd7, 1'b0, 6'd0, 32'd8);
    step();
    dispatch_packet = '0;
    mdu_rdy = 1'b1;
    @(negedge clk);
    chk("prerst_valid", mdu_packet.is_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pkt", mdu_packet, 0);
    chk("arst_rs_rdy", rs_rdy, 0);
    chk("arst_count", dut.count_q, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_valid", mdu_packet.is_valid, 0);
    chk("postrst_rs_rdy", rs_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
